tx_framer: RTL and testbench

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_framer.sv | 154 +++++++++++++++
 tb/tb_tx_framer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - transmit framer: STP/END/EDB packet framing with periodic SKP ordered sets
module tx_framer #(
  parameter int         SKP_INTERVAL = 16,
  parameter logic [7:0] COM          = 8'hBC,
  parameter logic [7:0] SKP          = 8'h1C,
  parameter logic [7:0] STP          = 8'hFB,
  parameter logic [7:0] END          = 8'hFD,
  parameter logic [7:0] EDB          = 8'hFE,
  parameter logic [7:0] IDL          = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic [7:0] tlp_data,
  input  logic       tlp_valid,
  input  logic       tlp_last,
  output logic       tlp_ready,
  output logic [7:0] data_out,
  output logic       k_out,
  output logic [3:0] S,
  output logic       err
);

  // Symbol-type codes reported on S
  localparam logic [3:0] S_IDL  = 4'd0;
  localparam logic [3:0] S_COM  = 4'd1;
  localparam logic [3:0] S_SKP  = 4'd2;
  localparam logic [3:0] S_STP  = 4'd3;
  localparam logic [3:0] S_DATA = 4'd4;
  localparam logic [3:0] S_END  = 4'd5;
  localparam logic [3:0] S_EDB  = 4'd6;

  localparam logic [7:0] WRAP_AT = 8'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE, DATA, ENDS, DROP, OS1, OS2, OS3
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       skp_pend, skp_pend_n;
  logic       pend_clr;
  logic       wrap;
  logic [7:0] dout_n;
  logic       k_n;
  logic [3:0] s_n;
  logic       err_n;

  // Source handshake is only open while a packet is being consumed or drained
  assign tlp_ready = enb && !reset && (state == DATA || state == DROP);

  // SKP interval counter; a wrap while a request is already pending does not queue another
  always_comb begin
    wrap       = (cnt == WRAP_AT);
    cnt_n      = wrap ? 8'd0 : cnt + 8'd1;
    skp_pend_n = wrap | (skp_pend & ~pend_clr);
  end

  // Next-state and next-symbol decision; ordered sets are only launched from IDLE
  always_comb begin
    state_n  = state;
    dout_n   = data_out;
    k_n      = k_out;
    s_n      = S;
    err_n    = 1'b0;
    pend_clr = 1'b0;
    case (state)
      IDLE: begin
        if (skp_pend) begin
          dout_n   = COM;
          k_n      = 1'b1;
          s_n      = S_COM;
          pend_clr = 1'b1;
          state_n  = OS1;
        end else if (tlp_valid) begin
          dout_n  = STP;
          k_n     = 1'b1;
          s_n     = S_STP;
          state_n = DATA;
        end else begin
          dout_n = IDL;
          k_n    = 1'b1;
          s_n    = S_IDL;
        end
      end
      OS1, OS2, OS3: begin
        dout_n = SKP;
        k_n    = 1'b1;
        s_n    = S_SKP;
        case (state)
          OS1:     state_n = OS2;
          OS2:     state_n = OS3;
          default: state_n = IDLE;
        endcase
      end
      DATA: begin
        if (tlp_valid) begin
          dout_n = tlp_data;
          k_n    = 1'b0;
          s_n    = S_DATA;
          if (tlp_last) state_n = ENDS;
        end else begin
          dout_n  = EDB;
          k_n     = 1'b1;
          s_n     = S_EDB;
          err_n   = 1'b1;
          state_n = DROP;
        end
      end
      ENDS: begin
        dout_n  = END;
        k_n     = 1'b1;
        s_n     = S_END;
        state_n = IDLE;
      end
      DROP: begin
        dout_n = IDL;
        k_n    = 1'b1;
        s_n    = S_IDL;
        if (tlp_valid && tlp_last) state_n = IDLE;
      end
      default: begin
        dout_n  = IDL;
        k_n     = 1'b1;
        s_n     = S_IDL;
        state_n = IDLE;
      end
    endcase
  end

  // State, counter and output registers; everything but err freezes while enb is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      skp_pend <= 1'b0;
      data_out <= IDL;
      k_out    <= 1'b1;
      S        <= S_IDL;
      err      <= 1'b0;
    end else if (enb) begin
      state    <= state_n;
      cnt      <= cnt_n;
      skp_pend <= skp_pend_n;
      data_out <= dout_n;
      k_out    <= k_n;
      S        <= s_n;
      err      <= err_n;
    end else begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// tb/tb_tx_framer.sv - directed vector bench for tx_framer
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic [7:0] tlp_data = 8'd0;
  logic       tlp_valid = 1'b0;
  logic       tlp_last = 1'b0;

  logic       ready_a, k_a, err_a;
  logic [7:0] dout_a;
  logic [3:0] s_a;
  logic       ready_b, k_b, err_b;
  logic [7:0] dout_b;
  logic [3:0] s_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_framer #(.SKP_INTERVAL(64)) u_a (
    .clk(clk), .reset(reset), .enb(enb),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_last(tlp_last),
    .tlp_ready(ready_a), .data_out(dout_a), .k_out(k_a), .S(s_a), .err(err_a)
  );

  tx_framer #(.SKP_INTERVAL(8)) u_b (
    .clk(clk), .reset(reset), .enb(enb),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_last(tlp_last),
    .tlp_ready(ready_b), .data_out(dout_b), .k_out(k_b), .S(s_b), .err(err_b)
  );

  typedef struct {
    logic       rst;
    logic       enb;
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] dout;
    logic       k;
    logic [3:0] s;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic en, input logic valid,
                              input logic last, input logic [7:0] data, input logic rdy,
                              input logic [7:0] dout, input logic k, input logic [3:0] s,
                              input logic e);
    vec_t v;
    v.rst = rst; v.enb = en; v.valid = valid; v.last = last; v.data = data;
    v.rdy = rdy; v.dout = dout; v.k = k; v.s = s; v.err = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enb = 1'b1; tlp_valid = 1'b0; tlp_last = 1'b0; tlp_data = 8'd0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Packet: FB,01..06,FD,7C
    add(1,1,0,0,8'h00, 0, 8'h7C,1,0,0);
    add(0,1,1,0,8'h01, 0, 8'hFB,1,3,0);
    add(0,1,1,0,8'h01, 1, 8'h01,0,4,0);
    add(0,1,1,0,8'h02, 1, 8'h02,0,4,0);
    add(0,1,1,0,8'h03, 1, 8'h03,0,4,0);
    add(0,1,1,0,8'h04, 1, 8'h04,0,4,0);
    add(0,1,1,0,8'h05, 1, 8'h05,0,4,0);
    add(0,1,1,1,8'h06, 1, 8'h06,0,4,0);
    add(0,1,0,0,8'h00, 0, 8'hFD,1,5,0);
    add(0,1,0,0,8'h00, 0, 8'h7C,1,0,0);
    // Underrun after 03, freeze during the err cycle, drain, next packet
    add(1,1,0,0,8'h00, 0, 8'h7C,1,0,0);
    add(0,1,1,0,8'h01, 0, 8'hFB,1,3,0);
    add(0,1,1,0,8'h01, 1, 8'h01,0,4,0);
    add(0,1,1,0,8'h02, 1, 8'h02,0,4,0);
    add(0,1,1,0,8'h03, 1, 8'h03,0,4,0);
    add(0,1,0,0,8'h00, 1, 8'hFE,1,6,1);
    add(0,0,1,0,8'h04, 0, 8'hFE,1,6,0);
    add(0,1,1,0,8'h04, 1, 8'h7C,1,0,0);
    add(0,1,1,1,8'h05, 1, 8'h7C,1,0,0);
    add(0,1,1,0,8'h0A, 0, 8'hFB,1,3,0);
    add(0,1,1,1,8'h0A, 1, 8'h0A,0,4,0);
    add(0,1,0,0,8'h00, 0, 8'hFD,1,5,0);
    // Freeze mid-packet for 3 cycles
    add(1,1,0,0,8'h00, 0, 8'h7C,1,0,0);
    add(0,1,1,0,8'h01, 0, 8'hFB,1,3,0);
    add(0,1,1,0,8'h01, 1, 8'h01,0,4,0);
    add(0,0,1,0,8'h02, 0, 8'h01,0,4,0);
    add(0,0,1,0,8'h02, 0, 8'h01,0,4,0);
    add(0,0,1,0,8'h02, 0, 8'h01,0,4,0);
    add(0,1,1,0,8'h02, 1, 8'h02,0,4,0);
    add(0,1,1,1,8'h03, 1, 8'h03,0,4,0);
    add(0,1,0,0,8'h00, 0, 8'hFD,1,5,0);
    // Reset mid-packet: no END/EDB, IDL follows, fresh 1-byte packet
    add(0,1,1,0,8'h01, 0, 8'hFB,1,3,0);
    add(0,1,1,0,8'h01, 1, 8'h01,0,4,0);
    add(1,1,1,0,8'h02, 0, 8'h7C,1,0,0);
    add(0,1,0,0,8'h00, 0, 8'h7C,1,0,0);
    add(0,1,1,1,8'h0A, 0, 8'hFB,1,3,0);
    add(0,1,1,1,8'h0A, 1, 8'h0A,0,4,0);
    add(0,1,0,0,8'h00, 0, 8'hFD,1,5,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enb = vecs[i].enb; tlp_valid = vecs[i].valid;
      tlp_last = vecs[i].last; tlp_data = vecs[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready_a), 32'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d_data", i), 32'(dout_a), 32'(vecs[i].dout));
      chk($sformatf("v%0d_k", i), 32'(k_a), 32'(vecs[i].k));
      chk($sformatf("v%0d_S", i), 32'(s_a), 32'(vecs[i].s));
      chk($sformatf("v%0d_err", i), 32'(err_a), 32'(vecs[i].err));
    end
    reset = 1'b0;

    // SKP insertion with an idle source, interval 8
    do_reset();
    chk("skp_cnt_after_reset", 32'(u_b.cnt), 32'd0);
    for (int i = 1; i <= 24; i++) begin
      logic [7:0] ed;
      logic [3:0] es;
      tick();
      if (i >= 9 && ((i - 9) % 8) == 0) begin ed = 8'hBC; es = 4'd1; end
      else if (i >= 9 && ((i - 9) % 8) <= 3) begin ed = 8'h1C; es = 4'd2; end
      else begin ed = 8'h7C; es = 4'd0; end
      chk($sformatf("skp%0d_data", i), 32'(dout_b), 32'(ed));
      chk($sformatf("skp%0d_S", i), 32'(s_b), 32'(es));
      chk($sformatf("skp%0d_k", i), 32'(k_b), 32'd1);
    end

    // Contention: 20-byte packet spans two wraps, then waiting 1-byte packet loses to SKP
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      logic [7:0] ed;
      logic [3:0] es;
      logic       ek;
      if (e <= 21) begin
        tlp_valid = 1'b1; tlp_data = (e == 1) ? 8'd1 : 8'(e - 1); tlp_last = (e == 21);
      end else if (e <= 32) begin
        tlp_valid = 1'b1; tlp_data = 8'h55; tlp_last = 1'b1;
      end else begin
        tlp_valid = 1'b0; tlp_last = 1'b0;
      end
      #1;
      if (e >= 23 && e <= 31) chk($sformatf("ct%0d_ready", e), 32'(ready_b), 32'd0);
      if (e == 32) chk("ct32_ready", 32'(ready_b), 32'd1);
      tick();
      ek = 1'b1;
      if (e == 1 || e == 31) begin ed = 8'hFB; es = 4'd3; end
      else if (e <= 21) begin ed = 8'(e - 1); es = 4'd4; ek = 1'b0; end
      else if (e == 22 || e == 33) begin ed = 8'hFD; es = 4'd5; end
      else if (e == 23 || e == 27 || e == 34) begin ed = 8'hBC; es = 4'd1; end
      else if (e == 32) begin ed = 8'h55; es = 4'd4; ek = 1'b0; end
      else begin ed = 8'h1C; es = 4'd2; end
      chk($sformatf("ct%0d_data", e), 32'(dout_b), 32'(ed));
      chk($sformatf("ct%0d_S", e), 32'(s_b), 32'(es));
      chk($sformatf("ct%0d_k", e), 32'(k_b), 32'(ek));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
